param_shift_register: RTL
=========================

Name: param_shift_register

Overview:
Parametrised universal shift register, the successor to the team's fixed 8-bit load/shift register. Features:
- Configurable width.
- Left/right shift, parallel load and hold modes, with global enable.
- Self-timed burst engine that shifts N positions autonomously with busy/done handshake.

It sits between parallel datapath registers and serial links, and serves as a SIPO/PISO building block.

Parameters:
WIDTH, 8, register width in bits (>=2)
LEN_W, 4, width of burst_len; max burst = 2^LEN_W-1 shifts

Ports:
clk  input  1  single clock, all state updates on posedge
clear  input  1  synchronous, active-high reset
en  input  1  global enable; 0 freezes register and burst counter
mode  input  2  00 hold, 01 shift left, 10 shift right, 11 parallel load
serial_in_l  input  1  bit entering out[0] on left shift
serial_in_r  input  1  bit entering out[WIDTH-1] on right shift
parallel_in  input  WIDTH  load data for mode 11
burst_start  input  1  request autonomous burst (sampled when idle)
burst_len  input  LEN_W  number of shifts in burst
burst_dir  input  1  0 = left, 1 = right, for burst
out  output  WIDTH  register contents
serial_out_l  output  1  combinational out[WIDTH-1]
serial_out_r  output  1  combinational out[0]
busy  output  1  high while burst in progress
done  output  1  one-cycle pulse at burst completion

Behaviour:
Interface: one clock; reset is synchronous and active-high.

Reset:
- clear=1 at posedge -> out=0, busy=0, done=0, counter=0, FSM=IDLE.
- clear has priority over everything, including en=0 and an active burst.

Shift operations:
- Left: out <= {out[WIDTH-2:0], serial_in_l}.
- Right: out <= {serial_in_r, out[WIDTH-1:1]}.

FSM states: IDLE, BURST.

IDLE:
- burst_start=1 and burst_len!=0 -> latch len into counter and burst_dir into dir reg; busy=1 next cycle; no shift on the accepting edge; mode ignored on that edge; go to BURST.
- burst_start=1 and burst_len=0 -> stay IDLE; done=1 for the following cycle; out unchanged; mode ignored that edge.
- burst_start accepted regardless of en.
- Otherwise, if en=1, apply mode. If en=0, hold.

BURST:
- mode and burst_start ignored.
- Each posedge with en=1: shift one position in latched dir using the corresponding serial_in, and decrement counter.
- When counter goes 1->0: busy falls, done pulses for exactly one cycle, return to IDLE.
- en=0 pauses the burst: no shift, no decrement, busy stays high.

Outputs and edge cases:
- done is registered and never high while busy=1.
- busy is registered.
- burst_len > WIDTH is legal: the register is fully replaced by serial input bits.
- clear mid-burst aborts the burst with no done pulse.

Optional Feature:
Macro: SHIFT_REG_ROTATE_EN
- Defined: adds input port rotate (1 bit).
- When rotate=1, left shift inserts out[WIDTH-1] into out[0] and right shift inserts out[0] into out[WIDTH-1], in both mode and burst operation. serial_in_l and serial_in_r are ignored.
- Not defined: port absent; serial inputs are always used.

Test Plan:
1. out=8'hA5, clear=1 for one edge with en=0 -> out=8'h00, busy=0, done=0.
2. en=1, mode=11, parallel_in=8'h3C -> out=8'h3C; then mode=01, serial_in_l=1 -> 8'h79; then mode=10, serial_in_r=0 -> 8'h3C. en=0 with mode=11, parallel_in=8'hFF -> 8'h3C holds.
3. out=8'hA5, burst_start with len=3, dir=0, serial_in_l=0:
   - Accept edge: out stays A5, busy=1.
   - Next edges: out=4A, 94, 28.
   - busy falls on the third shift edge; done=1 for one cycle.
   - Then with en dropped for 1 cycle mid-burst: busy lasts 4 cycles, same final value 8'h28.
4. While busy, pulse burst_start with len=5 and drive mode=11 -> ignored; burst completes with the original length. clear asserted mid-burst -> out=0, busy=0, no done pulse.
5. burst_start with len=0 -> busy stays 0, done=1 for one cycle next, out unchanged. len=10, dir=1, serial_in_r=1 -> out=8'hFF after 10 shifts.
6. (SHIFT_REG_ROTATE_EN) out=8'hA5, rotate=1, mode=01 -> 8'h4B; mode=10 from 8'hA5 -> 8'hD2. Burst len=8 rotate -> out returns to 8'hA5.

Source files
------------

// File: rtl/param_shift_register_if.sv
//------------------------------------------------------------------------------
// param_shift_register_if : control/data bundle of the universal shift register
// Optional rotate port when SHIFT_REG_ROTATE_EN is defined.   Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface param_shift_register_if #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4
);
   logic             en;
   logic [1:0]       mode;
   logic             serial_in_l;
   logic             serial_in_r;
   logic [WIDTH-1:0] parallel_in;
   logic             burst_start;
   logic [LEN_W-1:0] burst_len;
   logic             burst_dir;
   logic [WIDTH-1:0] out;
   logic             serial_out_l;
   logic             serial_out_r;
   logic             busy;
   logic             done;
`ifdef SHIFT_REG_ROTATE_EN
   logic             rotate;

   modport master (
      output en, mode, serial_in_l, serial_in_r, parallel_in,
             burst_start, burst_len, burst_dir, rotate,
      input  out, serial_out_l, serial_out_r, busy, done
   );
   modport slave (
      input  en, mode, serial_in_l, serial_in_r, parallel_in,
             burst_start, burst_len, burst_dir, rotate,
      output out, serial_out_l, serial_out_r, busy, done
   );
`else
   modport master (
      output en, mode, serial_in_l, serial_in_r, parallel_in,
             burst_start, burst_len, burst_dir,
      input  out, serial_out_l, serial_out_r, busy, done
   );
   modport slave (
      input  en, mode, serial_in_l, serial_in_r, parallel_in,
             burst_start, burst_len, burst_dir,
      output out, serial_out_l, serial_out_r, busy, done
   );
`endif
endinterface

`default_nettype wire

// File: rtl/param_shift_register.sv
//------------------------------------------------------------------------------
// param_shift_register : universal shift register with self-timed burst engine
// Optional feature macro: SHIFT_REG_ROTATE_EN (adds rotate input).   Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module param_shift_register #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4
) (
   input  wire logic             clk,
   input  wire logic             clear,
   param_shift_register_if.slave bus
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] out_q,   out_d;
   logic [LEN_W-1:0] cnt_q,   cnt_d;
   logic             dir_q,   dir_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;

   logic             rotate_on;
   logic             fill_l;
   logic             fill_r;
   logic [WIDTH-1:0] shl;
   logic [WIDTH-1:0] shr;

`ifdef SHIFT_REG_ROTATE_EN
   assign rotate_on = bus.rotate;
`else
   assign rotate_on = 1'b0;
`endif

   // Rotation recirculates the register's own end bits instead of the serial inputs.
   assign fill_l = rotate_on ? out_q[WIDTH-1] : bus.serial_in_l;
   assign fill_r = rotate_on ? out_q[0]       : bus.serial_in_r;
   assign shl    = {out_q[WIDTH-2:0], fill_l};
   assign shr    = {fill_r, out_q[WIDTH-1:1]};

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.burst_start) begin
               if (bus.burst_len != '0) begin
                  cnt_d   = bus.burst_len;
                  dir_d   = bus.burst_dir;
                  busy_d  = 1'b1;
                  state_d = BURST;
               end else begin
                  done_d = 1'b1;
               end
            end else if (bus.en) begin
               unique case (bus.mode)
                  2'b01:   out_d = shl;
                  2'b10:   out_d = shr;
                  2'b11:   out_d = bus.parallel_in;
                  default: out_d = out_q;
               endcase
            end
         end
         BURST: begin
            if (bus.en) begin
               out_d = dir_q ? shr : shl;
               cnt_d = cnt_q - LEN_W'(1);
               if (cnt_q == LEN_W'(1)) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q <= IDLE;
         out_q   <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.out          = out_q;
   assign bus.serial_out_l = out_q[WIDTH-1];
   assign bus.serial_out_r = out_q[0];
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;

endmodule

`default_nettype wire
